// File: rtl/lsb_serializer_pkg.sv
// Shared definitions for the LSB-first serializer and its matching deserializer:
// the two-state FSM encoding and the beat-counter width derivation.
package lsb_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    // Counter width for a WIDTH-bit frame; a 1-bit frame still needs a 1-bit counter.
    function automatic int cnt_width(input int width);
        return (width <= 32'sd1) ? 32'sd1 : $clog2(width);
    endfunction

endpackage

// File: rtl/lsb_serializer_if.sv
// Load and serial handshake bundle between the serializer and its neighbours.
interface lsb_serializer_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             ser_ready;
    logic             ser_valid;
    logic             ser_bit;
    logic             ser_first;
    logic             ser_last;
    logic             busy;

    modport master (
        output load_valid, load_data, ser_ready,
        input  load_ready, ser_valid, ser_bit, ser_first, ser_last, busy
    );

    modport slave (
        input  load_valid, load_data, ser_ready,
        output load_ready, ser_valid, ser_bit, ser_first, ser_last, busy
    );
endinterface

// File: rtl/lsb_serializer.sv
// Parallel-to-serial transmitter: accepts a WIDTH-bit word and emits it LSB first,
// one bit per accepted beat, with first/last markers and downstream backpressure.
module lsb_serializer
    import lsb_serializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    lsb_serializer_if.slave  bus
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic in_shift_s;
    logic last_beat_s;
    logic beat_s;
    logic load_ready_s;
    logic load_acc_s;

    assign in_shift_s   = (state_q == SHIFT);
    assign last_beat_s  = in_shift_s && (cnt_q == LAST_CNT);
    assign beat_s       = in_shift_s && bus.ser_ready;
    // Reload on the last beat's edge so consecutive frames run without a bubble.
    assign load_ready_s = !in_shift_s || (last_beat_s && bus.ser_ready);
    assign load_acc_s   = bus.load_valid && load_ready_s;

    // Next-state: a load takes priority over the final beat of the current frame.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        if (load_acc_s) begin
            state_d = SHIFT;
            sreg_d  = bus.load_data;
            cnt_d   = CNT_ZERO;
        end else if (beat_s) begin
            if (last_beat_s) begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end else begin
                sreg_d = sreg_q >> 1'b1;
                cnt_d  = cnt_q + CNT_ONE;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State, shift register and beat counter; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sreg_q  <= {WIDTH{1'b0}};
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.load_ready = load_ready_s;
    assign bus.ser_valid  = in_shift_s;
    assign bus.busy       = in_shift_s;
    assign bus.ser_bit    = in_shift_s && sreg_q[0];
    assign bus.ser_first  = in_shift_s && (cnt_q == CNT_ZERO);
    assign bus.ser_last   = last_beat_s;

endmodule
